// File: rtl/fifo_reader_pkg.sv
// Shared types and constants for the framed FIFO reader.
package fifo_reader_pkg;

  localparam int unsigned DSIZE_DEF = 8;
  localparam int unsigned CSIZE_DEF = 16;
  localparam int unsigned ZLEN_W    = 8;
  localparam int unsigned BUF_DEPTH = 2;
  localparam int unsigned CNT_W     = 2;
  localparam int unsigned FLAG_W    = 2;

  typedef enum logic {
    IDLE = 1'b0,
    DATA = 1'b1
  } state_t;

  // Saturating increment for the zero-length header counter.
  function automatic logic [ZLEN_W-1:0] sat_inc(input logic [ZLEN_W-1:0] v);
    return (v == {ZLEN_W{1'b1}}) ? v : v + ZLEN_W'(1);
  endfunction

endpackage

// File: rtl/fifo_reader_if.sv
// FIFO read-side and framed output stream signals.
interface fifo_reader_if #(
  parameter int unsigned DSIZE = 8
) ();
  logic             rempty;
  logic [DSIZE-1:0] rdata;
  logic             rd;
  logic [DSIZE-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_sof;
  logic             out_eof;

  modport master (
    input  rempty, rdata, out_ready,
    output rd, out_data, out_valid, out_sof, out_eof
  );

  modport slave (
    output rempty, rdata, out_ready,
    input  rd, out_data, out_valid, out_sof, out_eof
  );
endinterface

// File: rtl/fifo_reader_rd_skid_buf.sv
// Two-entry output buffer; head entry is held in its own register.
module rd_skid_buf
  import fifo_reader_pkg::*;
#(
  parameter int unsigned W = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [W-1:0]     in_data,
  input  logic             pop,
  output logic             out_valid,
  output logic [W-1:0]     out_data,
  output logic [CNT_W-1:0] count
);

  logic [W-1:0] tail;
  logic         do_pop;
  logic         do_push;

  assign do_pop    = pop && (count != '0);
  assign do_push   = push && ((count != CNT_W'(BUF_DEPTH)) || do_pop);
  assign out_valid = (count != '0);

  // Head/tail shuffle; simultaneous push and pop keeps count and order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= '0;
      tail     <= '0;
      count    <= '0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (count == '0) out_data <= in_data;
          else             tail     <= in_data;
          count <= count + CNT_W'(1);
        end
        2'b01: begin
          out_data <= tail;
          count    <= count - CNT_W'(1);
        end
        2'b11: begin
          if (count == CNT_W'(1)) begin
            out_data <= in_data;
          end else begin
            out_data <= tail;
            tail     <= in_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_reader.sv
// Splits a length-prefixed FIFO stream into sof/eof-tagged frames.
module fifo_reader
  import fifo_reader_pkg::*;
#(
  parameter int unsigned DSIZE = DSIZE_DEF,
  parameter int unsigned CSIZE = CSIZE_DEF
) (
  input  logic              rclk,
  input  logic              rrst_n,
  fifo_reader_if.master     bus,
  output logic              busy,
  output logic [CSIZE-1:0]  frm_cnt,
  output logic [ZLEN_W-1:0] zlen_cnt
);

  localparam int unsigned BW = DSIZE + FLAG_W;

  state_t            state, state_n;
  logic [DSIZE-1:0]  remain, remain_n;
  logic              first, first_n;
  logic [ZLEN_W-1:0] zlen_n;
  logic              rd_c;
  logic              push_c;
  logic [BW-1:0]     push_word_c;
  logic [BW-1:0]     head;
  logic              head_valid;
  logic [CNT_W-1:0]  buf_cnt;

  // Frame state registers.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state    <= IDLE;
      remain   <= '0;
      first    <= 1'b0;
      zlen_cnt <= '0;
    end else begin
      state    <= state_n;
      remain   <= remain_n;
      first    <= first_n;
      zlen_cnt <= zlen_n;
    end
  end

  // Header decode, payload pop/push and next-state selection.
  always_comb begin
    state_n     = state;
    remain_n    = remain;
    first_n     = first;
    zlen_n      = zlen_cnt;
    rd_c        = 1'b0;
    push_c      = 1'b0;
    push_word_c = {bus.rdata, first, (remain == DSIZE'(1))};
    case (state)
      IDLE: begin
        if (!bus.rempty) begin
          rd_c = 1'b1;
          if (bus.rdata == '0) begin
            zlen_n = sat_inc(zlen_cnt);
          end else begin
            remain_n = bus.rdata;
            first_n  = 1'b1;
            state_n  = DATA;
          end
        end
      end
      DATA: begin
        if (!bus.rempty && (buf_cnt < CNT_W'(BUF_DEPTH))) begin
          rd_c     = 1'b1;
          push_c   = 1'b1;
          remain_n = remain - DSIZE'(1);
          first_n  = 1'b0;
          if (remain == DSIZE'(1)) state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Pop strobe is forced low while reset is held.
  assign bus.rd = rd_c & rrst_n;

  rd_skid_buf #(
    .W (BW)
  ) u_buf (
    .clk       (rclk),
    .rst_n     (rrst_n),
    .push      (push_c),
    .in_data   (push_word_c),
    .pop       (bus.out_ready),
    .out_valid (head_valid),
    .out_data  (head),
    .count     (buf_cnt)
  );

  assign bus.out_valid = head_valid;
  assign bus.out_data  = head[BW-1 -: DSIZE];
  assign bus.out_sof   = head[1];
  assign bus.out_eof   = head[0];
  assign busy          = (state != IDLE) || (buf_cnt != '0);

  // Completed-frame counter, wraps naturally.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      frm_cnt <= '0;
    end else if (head_valid && bus.out_ready && head[0]) begin
      frm_cnt <= frm_cnt + CSIZE'(1);
    end
  end

endmodule

// File: tb/tb_fifo_reader.sv
// Directed bench for fifo_reader with a fall-through FIFO model.
module tb_fifo_reader;

  logic        clk;
  logic        rrst_n;
  logic        busy;
  logic [15:0] frm_cnt;
  logic [7:0]  zlen_cnt;

  fifo_reader_if #(.DSIZE(8)) bus ();

  fifo_reader #(
    .DSIZE (8),
    .CSIZE (16)
  ) dut (
    .rclk     (clk),
    .rrst_n   (rrst_n),
    .bus      (bus),
    .busy     (busy),
    .frm_cnt  (frm_cnt),
    .zlen_cnt (zlen_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int               n_in;
    logic [7:0][7:0]  in_w;
    int               n_out;
    logic [7:0][9:0]  ex;
    int               zl_inc;
    int               frm_inc;
    int               pops;
  } vec_t;

  int          checks;
  int          errors;
  int          cyc;
  int          pop_cnt;
  int          viol;
  logic        hold_empty;
  logic [7:0]  fq[$];
  logic [9:0]  rx[$];
  int          rx_cyc[$];
  vec_t        vt[4];

  function automatic logic [9:0] ent(input logic [7:0] d, input logic s, input logic f);
    return {d, s, f};
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive_fifo();
    bus.rempty = hold_empty || (fq.size() == 0);
    bus.rdata  = (fq.size() != 0) ? fq[0] : 8'h00;
  endtask

  // Called at posedge+1; returns at the following posedge+1.
  task automatic cycle();
    logic pre_rd;
    #8;
    pre_rd = bus.rd;
    if (bus.rd && bus.rempty) viol++;
    if (bus.out_valid && bus.out_ready) begin
      rx.push_back({bus.out_data, bus.out_sof, bus.out_eof});
      rx_cyc.push_back(cyc);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (pre_rd && fq.size() != 0) begin
      void'(fq.pop_front());
      pop_cnt++;
    end
    drive_fifo();
  endtask

  task automatic run_until_idle(input string nm, input int budget);
    int n;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!((fq.size() == 0) && !busy) && (n < budget));
    chk({nm, "_idle_timeout"}, int'((fq.size() == 0) && !busy), 1);
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, "_rd"},       int'(bus.rd), 0);
    chk({nm, "_valid"},    int'(bus.out_valid), 0);
    chk({nm, "_sof"},      int'(bus.out_sof), 0);
    chk({nm, "_eof"},      int'(bus.out_eof), 0);
    chk({nm, "_data"},     int'(bus.out_data), 0);
    chk({nm, "_busy"},     int'(busy), 0);
    chk({nm, "_frm_cnt"},  int'(frm_cnt), 0);
    chk({nm, "_zlen_cnt"}, int'(zlen_cnt), 0);
  endtask

  initial begin
    int         frm0, zl0, stable_err;
    logic [9:0] act;

    checks = 0; errors = 0; cyc = 0; pop_cnt = 0; viol = 0;
    hold_empty = 1'b0;
    bus.out_ready = 1'b1;
    rrst_n = 1'b0;
    fq.push_back(8'h07);
    drive_fifo();

    // Vectors: {3,A1..A3}, {1,B1}, {0,0,2,C1,C2}, {2,FF,00}.
    vt[0].n_in = 4; vt[0].in_w = '0;
    vt[0].in_w[0] = 8'h03; vt[0].in_w[1] = 8'hA1; vt[0].in_w[2] = 8'hA2; vt[0].in_w[3] = 8'hA3;
    vt[0].n_out = 3; vt[0].ex = '0;
    vt[0].ex[0] = ent(8'hA1, 1'b1, 1'b0); vt[0].ex[1] = ent(8'hA2, 1'b0, 1'b0); vt[0].ex[2] = ent(8'hA3, 1'b0, 1'b1);
    vt[0].zl_inc = 0; vt[0].frm_inc = 1; vt[0].pops = 4;

    vt[1].n_in = 2; vt[1].in_w = '0;
    vt[1].in_w[0] = 8'h01; vt[1].in_w[1] = 8'hB1;
    vt[1].n_out = 1; vt[1].ex = '0;
    vt[1].ex[0] = ent(8'hB1, 1'b1, 1'b1);
    vt[1].zl_inc = 0; vt[1].frm_inc = 1; vt[1].pops = 2;

    vt[2].n_in = 5; vt[2].in_w = '0;
    vt[2].in_w[0] = 8'h00; vt[2].in_w[1] = 8'h00; vt[2].in_w[2] = 8'h02; vt[2].in_w[3] = 8'hC1; vt[2].in_w[4] = 8'hC2;
    vt[2].n_out = 2; vt[2].ex = '0;
    vt[2].ex[0] = ent(8'hC1, 1'b1, 1'b0); vt[2].ex[1] = ent(8'hC2, 1'b0, 1'b1);
    vt[2].zl_inc = 2; vt[2].frm_inc = 1; vt[2].pops = 5;

    vt[3].n_in = 3; vt[3].in_w = '0;
    vt[3].in_w[0] = 8'h02; vt[3].in_w[1] = 8'hFF; vt[3].in_w[2] = 8'h00;
    vt[3].n_out = 2; vt[3].ex = '0;
    vt[3].ex[0] = ent(8'hFF, 1'b1, 1'b0); vt[3].ex[1] = ent(8'h00, 1'b0, 1'b1);
    vt[3].zl_inc = 0; vt[3].frm_inc = 1; vt[3].pops = 3;

    // Reset state with a non-empty FIFO: no pop may occur.
    @(posedge clk); #1;
    check_reset_outputs("reset");
    cycle(); cycle();
    chk("reset_no_pop", pop_cnt, 0);
    fq.delete();
    drive_fifo();
    rrst_n = 1'b1;
    cycle();

    // Table-driven frames with out_ready held high.
    for (int v = 0; v < 4; v++) begin
      frm0 = int'(frm_cnt); zl0 = int'(zlen_cnt);
      pop_cnt = 0; rx.delete(); rx_cyc.delete();
      for (int i = 0; i < vt[v].n_in; i++) fq.push_back(vt[v].in_w[i]);
      drive_fifo();
      run_until_idle($sformatf("vec%0d", v), 40);
      chk($sformatf("vec%0d_nout", v), rx.size(), vt[v].n_out);
      for (int i = 0; i < vt[v].n_out; i++) begin
        act = (i < rx.size()) ? rx[i] : 10'h3FF;
        chk($sformatf("vec%0d_word%0d", v, i), int'(act), int'(vt[v].ex[i]));
      end
      if (rx.size() == vt[v].n_out && vt[v].n_out > 1)
        chk($sformatf("vec%0d_back_to_back", v), rx_cyc[rx.size()-1] - rx_cyc[0], vt[v].n_out - 1);
      chk($sformatf("vec%0d_pops", v), pop_cnt, vt[v].pops);
      chk($sformatf("vec%0d_frm_inc", v), int'(frm_cnt) - frm0, vt[v].frm_inc);
      chk($sformatf("vec%0d_zlen_inc", v), int'(zlen_cnt) - zl0, vt[v].zl_inc);
    end

    // Backpressure: L=5 with out_ready low for 10 cycles.
    bus.out_ready = 1'b0;
    pop_cnt = 0; rx.delete(); rx_cyc.delete(); stable_err = 0;
    fq.push_back(8'h05);
    for (int i = 1; i <= 5; i++) fq.push_back(8'hE0 + 8'(i));
    drive_fifo();
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (i >= 2 && !(bus.out_valid && bus.out_data == 8'hE1 && bus.out_sof)) stable_err++;
    end
    chk("stall_pops", pop_cnt, 3);
    chk("stall_rd_low", int'(bus.rd), 0);
    chk("stall_head_stable", stable_err, 0);
    chk("stall_head_data", int'(bus.out_data), 32'hE1);
    bus.out_ready = 1'b1;
    run_until_idle("stall", 40);
    chk("stall_nout", rx.size(), 5);
    for (int i = 0; i < 5; i++) begin
      act = (i < rx.size()) ? rx[i] : 10'h3FF;
      chk($sformatf("stall_word%0d", i), int'(act),
          int'(ent(8'hE1 + 8'(i), (i == 0), (i == 4))));
    end

    // rempty toggling every cycle during a frame.
    rx.delete(); viol = 0;
    fq.push_back(8'h04);
    for (int i = 1; i <= 4; i++) fq.push_back(8'hF0 + 8'(i));
    for (int i = 0; i < 40 && !((fq.size() == 0) && !busy); i++) begin
      hold_empty = ~hold_empty;
      drive_fifo();
      cycle();
    end
    hold_empty = 1'b0;
    drive_fifo();
    chk("toggle_rd_vs_empty", viol, 0);
    chk("toggle_nout", rx.size(), 4);
    for (int i = 0; i < 4; i++) begin
      act = (i < rx.size()) ? rx[i] : 10'h3FF;
      chk($sformatf("toggle_word%0d", i), int'(act),
          int'(ent(8'hF1 + 8'(i), (i == 0), (i == 3))));
    end

    // Reset mid-frame after two of four payload words were popped.
    pop_cnt = 0; rx.delete();
    fq.push_back(8'h04);
    for (int i = 1; i <= 4; i++) fq.push_back(8'h40 + 8'(i));
    drive_fifo();
    for (int i = 0; i < 20 && pop_cnt < 3; i++) cycle();
    chk("midreset_reached", pop_cnt, 3);
    rrst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    fq.delete();
    fq.push_back(8'h02); fq.push_back(8'hD1); fq.push_back(8'hD2);
    drive_fifo();
    pop_cnt = 0;
    cycle();
    chk("midreset_no_pop", pop_cnt, 0);
    rrst_n = 1'b1;
    rx.delete();
    run_until_idle("postreset", 40);
    chk("postreset_nout", rx.size(), 2);
    act = (rx.size() > 0) ? rx[0] : 10'h3FF;
    chk("postreset_word0", int'(act), int'(ent(8'hD1, 1'b1, 1'b0)));
    act = (rx.size() > 1) ? rx[1] : 10'h3FF;
    chk("postreset_word1", int'(act), int'(ent(8'hD2, 1'b0, 1'b1)));
    chk("postreset_frm_cnt", int'(frm_cnt), 1);

    // zlen_cnt saturates at 255.
    rx.delete();
    for (int i = 0; i < 260; i++) fq.push_back(8'h00);
    drive_fifo();
    run_until_idle("zlen_sat", 400);
    chk("zlen_sat_value", int'(zlen_cnt), 255);
    chk("zlen_sat_no_output", rx.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1);
  end

endmodule
